// File: rtl/key_led_ctrl.sv
// Multi-key debouncer with press/release/long-press pulses, driving a LED
// pattern engine (rotate right/left, ping-pong, blink) with speed and pause.
module key_led_ctrl #(
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int LONG_CYC     = 100_000_000,
  parameter int STEP_BASE    = 25_000_000,
  parameter int NUM_KEYS     = 4,
  parameter int LED_W        = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_long,
  output logic [LED_W-1:0]    led,
  output logic [1:0]          mode,
  output logic [1:0]          speed,
  output logic                paused
);

  localparam int DB_W   = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int HOLD_W = (LONG_CYC > 2) ? $clog2(LONG_CYC) : 2;
  localparam int DIV_W  = $clog2(STEP_BASE);

  localparam logic [DB_W-1:0]   DB_MAX    = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYC - 1);
  localparam logic [HOLD_W-1:0] HOLD_FIRE = HOLD_W'(LONG_CYC - 2);

  localparam logic [1:0] MODE_ROR   = 2'd0;
  localparam logic [1:0] MODE_ROL   = 2'd1;
  localparam logic [1:0] MODE_PING  = 2'd2;
  localparam logic [1:0] MODE_BLINK = 2'd3;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  logic [NUM_KEYS-1:0]             sync1_q, sync1_d, sync2_q, sync2_d;
  logic [NUM_KEYS-1:0]             level_q, level_d;
  logic [NUM_KEYS-1:0]             press_q, press_d, release_q, release_d;
  logic [NUM_KEYS-1:0]             long_q, long_d;
  logic [NUM_KEYS-1:0][DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic [NUM_KEYS-1:0][HOLD_W-1:0] hold_q, hold_d;

  logic [LED_W-1:0] led_q, led_d;
  logic [1:0]       mode_q, mode_d, speed_q, speed_d;
  logic             paused_q, paused_d, dir_q, dir_d;
  logic [DIV_W-1:0] div_q, div_d, div_term;
  logic             step, reinit, div_clr;

  // The counter compares the incoming sample (sync1) with the one before it
  // (sync2), so key_level moves DEBOUNCE_CYC+2 edges after the pin settles.
  always_comb begin
    sync1_d   = key;
    sync2_d   = sync1_q;
    db_cnt_d  = db_cnt_q;
    hold_d    = hold_q;
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    long_d    = '0;
    for (int unsigned i = 0; i < NUM_KEYS; i++) begin
      if (sync1_q[i] != sync2_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] != DB_MAX) begin
        db_cnt_d[i] = db_cnt_q[i] + 1'b1;
      end
      if ((db_cnt_q[i] == DB_MAX) && (sync2_q[i] != level_q[i])) begin
        level_d[i]   = sync2_q[i];
        press_d[i]   = ~sync2_q[i];
        release_d[i] = sync2_q[i];
      end
      if (level_q[i]) begin
        hold_d[i] = '0;
      end else if (hold_q[i] != HOLD_MAX) begin
        hold_d[i] = hold_q[i] + 1'b1;
      end
      long_d[i] = ~level_q[i] & (hold_q[i] == HOLD_FIRE);
    end
  end

  always_comb begin
    div_term = DIV_W'((STEP_BASE >> speed_q) - 1);
  end

  always_comb begin
    mode_d   = mode_q;
    speed_d  = speed_q;
    paused_d = paused_q;
    led_d    = led_q;
    dir_d    = dir_q;
    div_d    = div_q;
    reinit   = 1'b0;
    div_clr  = 1'b0;
    step     = ~paused_q & (div_q == div_term);

    if (long_q[3]) begin
      mode_d   = MODE_ROR;
      speed_d  = '0;
      paused_d = 1'b0;
      reinit   = 1'b1;
      div_clr  = 1'b1;
    end else begin
      if (press_q[0]) begin
        mode_d  = mode_q + 2'd1;
        reinit  = 1'b1;
        div_clr = 1'b1;
      end
      if (press_q[1]) begin
        speed_d = speed_q + 2'd1;
        div_clr = 1'b1;
      end
      if (press_q[2]) begin
        paused_d = ~paused_q;
      end
    end

    if (div_clr) begin
      div_d = '0;
    end else if (!paused_q) begin
      div_d = step ? '0 : div_q + 1'b1;
    end

    // A reinit takes precedence over a step landing on the same edge.
    if (reinit) begin
      dir_d = DIR_UP;
      led_d = (mode_d == MODE_BLINK) ? '1 : LED_W'(1);
    end else if (step) begin
      case (mode_q)
        MODE_ROR: led_d = {led_q[0], led_q[LED_W-1:1]};
        MODE_ROL: led_d = {led_q[LED_W-2:0], led_q[LED_W-1]};
        MODE_PING: begin
          if (dir_q == DIR_UP) begin
            led_d = led_q << 1;
            if (led_d[LED_W-1]) dir_d = DIR_DN;
          end else begin
            led_d = led_q >> 1;
            if (led_d[0]) dir_d = DIR_UP;
          end
        end
        default: led_d = ~led_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= '1;
      sync2_q   <= '1;
      level_q   <= '1;
      press_q   <= '0;
      release_q <= '0;
      long_q    <= '0;
      db_cnt_q  <= '0;
      hold_q    <= '0;
      led_q     <= LED_W'(1);
      mode_q    <= MODE_ROR;
      speed_q   <= '0;
      paused_q  <= 1'b0;
      dir_q     <= DIR_UP;
      div_q     <= '0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      db_cnt_q  <= db_cnt_d;
      hold_q    <= hold_d;
      led_q     <= led_d;
      mode_q    <= mode_d;
      speed_q   <= speed_d;
      paused_q  <= paused_d;
      dir_q     <= dir_d;
      div_q     <= div_d;
    end
  end

  assign key_level   = level_q;
  assign key_press   = press_q;
  assign key_release = release_q;
  assign key_long    = long_q;
  assign led         = led_q;
  assign mode        = mode_q;
  assign speed       = speed_q;
  assign paused      = paused_q;

endmodule

// File: tb/tb_key_led_ctrl.sv
// Randomized bench for key_led_ctrl against a sample-window / position-based
// reference model, plus directed checks of the key timing points.
module tb_key_led_ctrl;
  localparam int D  = 8;
  localparam int L  = 64;
  localparam int SB = 16;
  localparam int NK = 4;
  localparam int W  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [NK-1:0] key;
  logic [NK-1:0] key_level, key_press, key_release, key_long;
  logic [W-1:0]  led;
  logic [1:0]    mode, speed;
  logic          paused;

  always #5 clk = ~clk;

  key_led_ctrl #(
    .DEBOUNCE_CYC(D),
    .LONG_CYC    (L),
    .STEP_BASE   (SB),
    .NUM_KEYS    (NK),
    .LED_W       (W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key        (key),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .key_long   (key_long),
    .led        (led),
    .mode       (mode),
    .speed      (speed),
    .paused     (paused)
  );

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: raw-sample history per key, LED as a lit position.
  bit              hist [NK][$];
  bit              m_level [NK];
  bit              m_press [NK];
  bit              m_rel   [NK];
  bit              m_long  [NK];
  bit              pp [NK];
  bit              pl [NK];
  longint unsigned press_at [NK];
  longint unsigned edge_n = 0;
  int              m_mode, m_speed, m_pos, m_t;
  bit              m_paused, m_up, m_blink_on, old_paused;
  bit              step, reinit, clr;

  function automatic bit window_stable(input int k);
    for (int i = 1; i < D; i++)
      if (hist[k][i] != hist[k][0]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [NK-1:0] pk(input bit a [NK]);
    logic [NK-1:0] v;
    for (int i = 0; i < NK; i++) v[i] = a[i];
    return v;
  endfunction

  function automatic logic [W-1:0] exp_led();
    if (m_mode == 3) return m_blink_on ? '1 : '0;
    return W'(1) << m_pos;
  endfunction

  always @(posedge clk) begin
    edge_n++;
    if (rst) begin
      for (int k = 0; k < NK; k++) begin
        hist[k].delete();
        hist[k].push_back(1'b1);
        hist[k].push_back(1'b1);
        m_level[k] = 1'b1;
        m_press[k] = 1'b0;
        m_rel[k]   = 1'b0;
        m_long[k]  = 1'b0;
        press_at[k] = 0;
      end
      m_mode = 0; m_speed = 0; m_paused = 1'b0; m_pos = 0; m_up = 1'b1;
      m_blink_on = 1'b0; m_t = 0;
    end else begin
      pp = m_press;
      pl = m_long;
      for (int k = 0; k < NK; k++) begin
        m_press[k] = 1'b0;
        m_rel[k]   = 1'b0;
        m_long[k]  = !m_level[k] && (edge_n - press_at[k] == L - 1);
        if (hist[k].size() == D + 1 && window_stable(k) && hist[k][0] != m_level[k]) begin
          m_level[k] = hist[k][0];
          if (m_level[k]) m_rel[k] = 1'b1;
          else begin
            m_press[k]  = 1'b1;
            press_at[k] = edge_n;
          end
        end
        hist[k].push_back(key[k]);
        if (hist[k].size() > D + 1) void'(hist[k].pop_front());
      end

      old_paused = m_paused;
      step   = !m_paused && (m_t + 1 == (SB >> m_speed));
      reinit = 1'b0;
      clr    = 1'b0;
      if (pl[3]) begin
        m_mode = 0; m_speed = 0; m_paused = 1'b0; reinit = 1'b1; clr = 1'b1;
      end else begin
        if (pp[0]) begin m_mode = (m_mode + 1) % 4; reinit = 1'b1; clr = 1'b1; end
        if (pp[1]) begin m_speed = (m_speed + 1) % 4; clr = 1'b1; end
        if (pp[2]) m_paused = !m_paused;
      end
      if (clr) m_t = 0;
      else if (!old_paused) m_t = step ? 0 : m_t + 1;

      if (reinit) begin
        if (m_mode == 3) m_blink_on = 1'b1;
        else begin m_pos = 0; m_up = 1'b1; end
      end else if (step) begin
        case (m_mode)
          0: m_pos = (m_pos + W - 1) % W;
          1: m_pos = (m_pos + 1) % W;
          2: begin
            m_pos = m_up ? m_pos + 1 : m_pos - 1;
            if (m_pos == W - 1) m_up = 1'b0;
            else if (m_pos == 0) m_up = 1'b1;
          end
          default: m_blink_on = !m_blink_on;
        endcase
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (check_en) begin
      check("key_level",   key_level,   pk(m_level));
      check("key_press",   key_press,   pk(m_press));
      check("key_release", key_release, pk(m_rel));
      check("key_long",    key_long,    pk(m_long));
      check("led",         led,         exp_led());
      check("mode",        mode,        m_mode);
      check("speed",       speed,       m_speed);
      check("paused",      paused,      m_paused);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Settle key k at value v after nb short bounces (each run 1..3 cycles).
  task automatic drive_key(input int k, input bit v, input int nb);
    for (int i = 0; i < nb; i++) begin
      key[k] = v;
      repeat ($urandom_range(1, 3)) @(negedge clk);
      key[k] = ~v;
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    key[k] = v;
  endtask

  task automatic press_key(input int k, input int hold, input int nb, input int gap);
    drive_key(k, 1'b0, nb);
    idle(hold);
    drive_key(k, 1'b1, nb);
    idle(gap);
  endtask

  int rk, rr, rh;

  initial begin
    rst = 1'b1;
    key = '1;
    @(negedge clk);
    check_en = 1'b1;
    @(negedge clk);
    check("rst_led", led, 4'b0001);
    check("rst_level", key_level, 4'hF);
    check("rst_mode", mode, 2'd0);
    rst = 1'b0;

    repeat (15) @(posedge clk);
    #1 check("step_pre16", led, 4'b0001);
    @(posedge clk);
    #1 check("step16", led, 4'b1000);
    repeat (16) @(posedge clk);
    #1 check("step32", led, 4'b0100);
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      key[0] = ~key[0];
      repeat (3) @(negedge clk);
    end
    key[0] = 1'b0;
    repeat (9) @(posedge clk);
    #1 check("db_edge9_level", key_level[0], 1'b1);
    check("db_edge9_press", key_press[0], 1'b0);
    @(posedge clk);
    #1 check("db_edge10_level", key_level[0], 1'b0);
    check("db_edge10_press", key_press[0], 1'b1);
    @(posedge clk);
    #1 check("db_single_pulse", key_press[0], 1'b0);
    @(negedge clk);
    drive_key(0, 1'b1, 2);
    idle(20);

    press_key(1, 15, 2, 20);
    press_key(1, 15, 1, 20);
    check("speed2", speed, 2'd2);
    idle(20);

    press_key(0, 15, 2, 50);
    check("mode_ping", mode, 2'd2);
    press_key(0, 15, 1, 10);
    check("mode_blink", mode, 2'd3);
    press_key(2, 12, 1, 10);
    check("paused_on", paused, 1'b1);
    idle(120);
    press_key(2, 12, 1, 30);
    check("paused_off", paused, 1'b0);

    press_key(3, 80, 2, 30);
    check("long_mode", mode, 2'd0);
    check("long_speed", speed, 2'd0);
    press_key(3, 20, 1, 30);

    press_key(0, 12, 0, 12);
    press_key(0, 12, 0, 12);
    key[0] = 1'b0;
    idle(4);
    rst = 1'b1;
    key[0] = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_mode", mode, 2'd0);
    check("midrst_led", led, 4'b0001);
    check("midrst_level", key_level, 4'hF);
    idle(30);

    for (int s = 0; s < 160; s++) begin
      rk = $urandom_range(0, NK - 1);
      rr = $urandom_range(0, 19);
      if (rr == 0) begin
        rst = 1'b1;
        key = NK'($urandom);
        @(negedge clk);
        rst = 1'b0;
        key = '1;
        idle($urandom_range(1, 20));
      end else if (rr < 4) begin
        idle($urandom_range(5, 60));
      end else begin
        if (rk == 3 && rr < 9) rh = $urandom_range(58, 90);
        else rh = $urandom_range(1, 30);
        press_key(rk, rh, $urandom_range(0, 3), $urandom_range(0, 25));
      end
    end
    idle(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
